// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, encodings and helpers for the memory controller
package mem_ctrl_pkg;
  localparam int DATA_WIDTH        = 32;
  localparam int RAM_ADDRESS_WIDTH = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  // addresses with this prefix at [17:16] go to the IO write buffer
  localparam logic [1:0] IO_PREFIX = 2'b11;

  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // one latched request: fetches use size 4 unsigned, only stores use data
  typedef struct packed {
    logic [RAM_ADDRESS_WIDTH-1:0] addr;
    logic [2:0]                   size;
    logic                         sgn;
    logic [DATA_WIDTH-1:0]        data;
  } req_t;

  function automatic logic is_io_prefix(input logic [1:0] addr_hi);
    return addr_hi == IO_PREFIX;
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - requester and RAM-port signals of the memory controller
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                         rdy;
  logic                         in_misbranch;
  logic                         in_io_buffer_full;

  logic                         in_fetcher_req;
  logic [RAM_ADDRESS_WIDTH-1:0] in_fetcher_addr;
  logic                         out_fetcher_done;
  logic [DATA_WIDTH-1:0]        out_fetcher_data;

  logic                         in_slb_req;
  logic [RAM_ADDRESS_WIDTH-1:0] in_slb_addr;
  logic [2:0]                   in_slb_size;
  logic                         in_slb_signed;
  logic                         out_slb_done;
  logic [DATA_WIDTH-1:0]        out_slb_data;

  logic                         in_rob_req;
  logic [RAM_ADDRESS_WIDTH-1:0] in_rob_addr;
  logic [2:0]                   in_rob_size;
  logic [DATA_WIDTH-1:0]        in_rob_data;
  logic                         out_rob_done;

  logic [7:0]                   mem_din;
  logic [7:0]                   mem_dout;
  logic [RAM_ADDRESS_WIDTH-1:0] mem_a;
  logic                         mem_wr;

  // controller side
  modport slave (
    input  rdy, in_misbranch, in_io_buffer_full,
    input  in_fetcher_req, in_fetcher_addr,
    output out_fetcher_done, out_fetcher_data,
    input  in_slb_req, in_slb_addr, in_slb_size, in_slb_signed,
    output out_slb_done, out_slb_data,
    input  in_rob_req, in_rob_addr, in_rob_size, in_rob_data,
    output out_rob_done,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );

  // requesters and RAM side
  modport master (
    output rdy, in_misbranch, in_io_buffer_full,
    output in_fetcher_req, in_fetcher_addr,
    input  out_fetcher_done, out_fetcher_data,
    output in_slb_req, in_slb_addr, in_slb_size, in_slb_signed,
    input  out_slb_done, out_slb_data,
    output in_rob_req, in_rob_addr, in_rob_size, in_rob_data,
    input  out_rob_done,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_load_extend.sv
// rtl/mem_ctrl_load_extend.sv - size/signed extension of an assembled load word
module mem_ctrl_load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [2:0]            size,
  input  logic                  sgn,
  output logic [DATA_WIDTH-1:0] value
);

  // fill the upper bits from the top bit of the loaded width when signed
  always_comb begin
    value = word;
    case (size)
      SIZE_BYTE: value = {{24{sgn & word[7]}}, word[7:0]};
      SIZE_HALF: value = {{16{sgn & word[15]}}, word[15:0]};
      default:   value = word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial arbiter/sequencer for the shared 8-bit RAM port
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  state_t                       state, state_next;
  logic [2:0]                   idx;
  logic [1:0]                   idx_prev;
  req_t                         cur;
  logic                         cur_fetch;
  logic [DATA_WIDTH-1:0]        rd_buf, rd_word, rd_ext;
  logic [RAM_ADDRESS_WIDTH-1:0] byte_addr;

  logic                         pend_f, pend_l, pend_s;
  req_t                         slot_f, slot_l, slot_s;

  logic                         grant_f, grant_l, grant_s;
  logic                         rd_step, rd_finish, wr_step, wr_finish;

  assign byte_addr = cur.addr + {29'd0, idx};
  assign idx_prev  = idx[1:0] - 2'd1;

  // merge the byte returned for the previous address into the partial word
  always_comb begin
    rd_word = rd_buf;
    if (idx != 3'd0) rd_word[{idx_prev, 3'b000} +: 8] = bus.mem_din;
  end

  mem_ctrl_load_extend u_load_extend (
    .word  (rd_word),
    .size  (cur.size),
    .sgn   (cur.sgn),
    .value (rd_ext)
  );

  // arbitration (store > load > fetch), byte sequencing and RAM port drive
  always_comb begin
    state_next   = state;
    grant_f      = FALSE;
    grant_l      = FALSE;
    grant_s      = FALSE;
    rd_step      = FALSE;
    rd_finish    = FALSE;
    wr_step      = FALSE;
    wr_finish    = FALSE;
    bus.mem_a    = '0;
    bus.mem_dout = 8'h00;
    bus.mem_wr   = FALSE;
    case (state)
      IDLE: begin
        if (pend_s) begin
          grant_s    = TRUE;
          state_next = WRITE;
        end else if (pend_l && !bus.in_misbranch) begin
          grant_l    = TRUE;
          state_next = READ;
        end else if (pend_f && !bus.in_misbranch) begin
          grant_f    = TRUE;
          state_next = READ;
        end
      end
      READ: begin
        bus.mem_a = byte_addr;
        if (bus.in_misbranch) begin
          state_next = IDLE;
        end else if (idx == cur.size) begin
          rd_finish  = TRUE;
          state_next = IDLE;
        end else begin
          rd_step = TRUE;
        end
      end
      WRITE: begin
        bus.mem_a    = byte_addr;
        bus.mem_dout = cur.data[{idx[1:0], 3'b000} +: 8];
        // a full IO buffer holds the byte back; idx waits with it
        if (!(is_io_prefix(byte_addr[17:16]) && bus.in_io_buffer_full)) begin
          bus.mem_wr = TRUE;
          wr_step    = TRUE;
          if (idx == cur.size - 3'd1) begin
            wr_finish  = TRUE;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (!bus.rdy) begin
      state_next = state;
      grant_f    = FALSE;
      grant_l    = FALSE;
      grant_s    = FALSE;
      rd_step    = FALSE;
      rd_finish  = FALSE;
      wr_step    = FALSE;
      wr_finish  = FALSE;
      bus.mem_wr = FALSE;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // request slots, byte counter, read assembly and registered done/data outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_f               <= FALSE;
      pend_l               <= FALSE;
      pend_s               <= FALSE;
      slot_f               <= '0;
      slot_l               <= '0;
      slot_s               <= '0;
      cur                  <= '0;
      cur_fetch            <= FALSE;
      idx                  <= 3'd0;
      rd_buf               <= ZERO_DATA;
      bus.out_fetcher_done <= FALSE;
      bus.out_fetcher_data <= ZERO_DATA;
      bus.out_slb_done     <= FALSE;
      bus.out_slb_data     <= ZERO_DATA;
      bus.out_rob_done     <= FALSE;
    end else if (bus.rdy) begin
      bus.out_fetcher_done <= FALSE;
      bus.out_slb_done     <= FALSE;
      bus.out_rob_done     <= FALSE;

      // speculative slots are flushed by a misbranch, dropping a same-cycle pulse
      if (bus.in_misbranch || grant_f) begin
        pend_f <= FALSE;
      end else if (bus.in_fetcher_req && !pend_f) begin
        pend_f <= TRUE;
        slot_f <= '{addr: bus.in_fetcher_addr, size: SIZE_WORD, sgn: FALSE, data: ZERO_DATA};
      end

      if (bus.in_misbranch || grant_l) begin
        pend_l <= FALSE;
      end else if (bus.in_slb_req && !pend_l) begin
        pend_l <= TRUE;
        slot_l <= '{addr: bus.in_slb_addr, size: bus.in_slb_size,
                    sgn: bus.in_slb_signed, data: ZERO_DATA};
      end

      if (grant_s) begin
        pend_s <= FALSE;
      end else if (bus.in_rob_req && !pend_s) begin
        pend_s <= TRUE;
        slot_s <= '{addr: bus.in_rob_addr, size: bus.in_rob_size,
                    sgn: FALSE, data: bus.in_rob_data};
      end

      if (grant_s || grant_l || grant_f) begin
        idx       <= 3'd0;
        rd_buf    <= ZERO_DATA;
        cur_fetch <= grant_f;
        cur       <= grant_s ? slot_s : (grant_l ? slot_l : slot_f);
      end

      if (rd_step || wr_step) idx <= idx + 3'd1;
      if (rd_step) rd_buf <= rd_word;

      if (rd_finish) begin
        if (cur_fetch) begin
          bus.out_fetcher_done <= TRUE;
          bus.out_fetcher_data <= rd_ext;
        end else begin
          bus.out_slb_done <= TRUE;
          bus.out_slb_data <= rd_ext;
        end
      end

      if (wr_finish) bus.out_rob_done <= TRUE;
    end
  end

endmodule
